// File: rtl/bcd_disp_pkg.sv
// Shared constants for the two-digit BCD display path: raw segment
// patterns in {g,f,e,d,c,b,a} order (1 = segment lit) and scan slot ids.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Which digit the scan is currently driving.
    typedef enum logic {
        SLOT_ONES = 1'b0,
        SLOT_TENS = 1'b1
    } slot_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder. Codes 10..15 are not valid BCD
// and are shown as a dash (segment g only) so a bad count is visible.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Map each BCD code to its raw (active-high) segment pattern.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd2_seg_scanner.sv
// Two-digit multiplexed 7-segment driver. A prescaler splits each frame
// into a ones slot and a tens slot of REFRESH_DIV cycles each. Digits are
// snapshotted only at frame end so a frame never mixes old and new values.
// Each slot opens with DEAD_CYCLES of all-anodes-off to stop ghosting while
// the shared segment bus changes. Pins are registered (1 cycle latency)
// and polarity is applied at that register.
module bcd2_seg_scanner
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int DEAD_CYCLES    = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // XOR masks: an all-ones mask inverts the raw active-high value.
    localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [1:0] AN_POL  = {2{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0] cnt;
    slot_e            slot;
    logic [3:0]       s1;
    logic [3:0]       s0;

    logic             in_dead;
    logic [1:0]       an_int;
    logic [3:0]       digit;
    logic [6:0]       seg_dec;
    logic [6:0]       seg_int;

    // Dead window at the head of each slot; a zero length removes it.
    if (DEAD_CYCLES > 0) begin : g_dead
        localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYCLES);
        assign in_dead = (cnt < DEAD_LIM);
    end else begin : g_no_dead
        assign in_dead = 1'b0;
    end

    // Prescaler, slot toggle and frame-end snapshot of the incoming digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            slot        <= SLOT_ONES;
            s1          <= 4'd0;
            s0          <= 4'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                slot <= (slot == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
                if (slot == SLOT_TENS) begin
                    s1          <= d1;
                    s0          <= d0;
                    frame_start <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Raw anode choice; blank_lz is used live so it takes effect mid-frame.
    always_comb begin
        an_int = 2'b00;
        if (!in_dead) begin
            if (slot == SLOT_ONES) begin
                an_int = 2'b01;
            end else if (!(blank_lz && (s1 == 4'd0))) begin
                an_int = 2'b10;
            end
        end
    end

    assign digit = (slot == SLOT_TENS) ? s1 : s0;

    bcd_to_seg7 u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

    // Segments go dark whenever no anode is lit so nothing leaks into the gap.
    always_comb begin
        seg_int = seg_dec;
        if (an_int == 2'b00) begin
            seg_int = SEG_OFF;
        end
    end

    // Pin register with polarity applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_POL;
            seg <= SEG_OFF ^ SEG_POL;
        end else begin
            an  <= an_int ^ AN_POL;
            seg <= seg_int ^ SEG_POL;
        end
    end

endmodule
